// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - saturating score counter, double-dabble BCD converter, frame-synchronous digit commit
// Optional high-score register enabled by defining HISCORE_EN.
module score_ctrl #(
  parameter int SCORE_W   = 8,
  parameter int MAX_SCORE = 99,
  parameter int PEND_W    = 4
) (
  input  logic               VGA_clk,
  input  logic               rst_n,
  input  logic               point,
  input  logic               clear,
  input  logic               frame_start,
  output logic [SCORE_W-1:0] score,
  output logic               saturated,
  output logic               busy,
  output logic [3:0]         disp_tens,
  output logic [3:0]         disp_ones,
  output logic               disp_stb,
  output logic [3:0]         hi_tens,
  output logic [3:0]         hi_ones
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WAITVB} state_t;

  localparam int                 CNT_W    = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [PEND_W-1:0]  r_pend;
  logic [SCORE_W-1:0] r_bin;
  logic [7:0]         r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic               r_stb;

  logic               w_at_max;
  logic               w_pend_nz;
  logic [SCORE_W-1:0] w_score_inc;
  logic [7:0]         w_bcd_adj;

  assign w_at_max    = (r_score == MAX_S);
  assign w_pend_nz   = (r_pend != '0);
  assign w_score_inc = r_score + SCORE_W'(1);

  // Two nibbles are enough: the score never exceeds 99, so no hundreds carry.
  always_comb begin
    w_bcd_adj = r_bcd;
    if (r_bcd[3:0] >= 4'd5) w_bcd_adj[3:0] = r_bcd[3:0] + 4'd3;
    if (r_bcd[7:4] >= 4'd5) w_bcd_adj[7:4] = r_bcd[7:4] + 4'd3;
  end

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_score <= '0;
      r_pend  <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (clear) begin
        r_score <= '0;
        r_pend  <= '0;
        r_bin   <= '0;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_state <= S_CONV;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_at_max) begin
              r_pend <= '0;
            end else if (w_pend_nz || point) begin
              // A fresh point replaces the pending one it would otherwise add to.
              r_score <= w_score_inc;
              r_bin   <= w_score_inc;
              r_bcd   <= '0;
              r_cnt   <= '0;
              r_state <= S_CONV;
              if (w_pend_nz && !point) r_pend <= r_pend - PEND_W'(1);
            end
          end
          S_CONV: begin
            r_bcd <= {w_bcd_adj[6:0], r_bin[SCORE_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) r_state <= S_WAITVB;
          end
          S_WAITVB: begin
            if (frame_start) begin
              r_tens  <= r_bcd[7:4];
              r_ones  <= r_bcd[3:0];
              r_stb   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
        if (r_state != S_IDLE && point && !w_at_max && r_pend != PEND_MAX)
          r_pend <= r_pend + PEND_W'(1);
      end
    end
  end

`ifdef HISCORE_EN
  logic [7:0] r_hi;

  // Packed BCD compares in the same order as the decimal value.
  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      r_hi <= 8'd0;
    end else if (!clear && r_state == S_WAITVB && frame_start && r_bcd > r_hi) begin
      r_hi <= r_bcd;
    end
  end

  assign hi_tens = r_hi[7:4];
  assign hi_ones = r_hi[3:0];
`else
  assign hi_tens = 4'd0;
  assign hi_ones = 4'd0;
`endif

  assign score     = r_score;
  assign saturated = w_at_max;
  assign busy      = (r_state != S_IDLE);
  assign disp_tens = r_tens;
  assign disp_ones = r_ones;
  assign disp_stb  = r_stb;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - directed and random stimulus for score_ctrl against a decimal reference model
module tb_score_ctrl;

  localparam int SW   = 8;
  localparam int MAXS = 99;
  localparam int PMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       point;
  logic       clear;
  logic       frame_start;
  logic [7:0] score;
  logic       saturated;
  logic       busy;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       disp_stb;
  logic [3:0] hi_tens;
  logic [3:0] hi_ones;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_score, m_pend, m_val, m_ready, m_tens, m_ones, m_hi, cyc;
  bit m_busy, m_stb;

  score_ctrl #(.SCORE_W(8), .MAX_SCORE(99), .PEND_W(4)) dut (
    .VGA_clk    (clk),
    .rst_n      (rst_n),
    .point      (point),
    .clear      (clear),
    .frame_start(frame_start),
    .score      (score),
    .saturated  (saturated),
    .busy       (busy),
    .disp_tens  (disp_tens),
    .disp_ones  (disp_ones),
    .disp_stb   (disp_stb),
    .hi_tens    (hi_tens),
    .hi_ones    (hi_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int eh;
`ifdef HISCORE_EN
    eh = m_hi;
`else
    eh = 0;
`endif
    check("score", 32'(score), m_score);
    check("saturated", 32'(saturated), (m_score == MAXS) ? 1 : 0);
    check("busy", 32'(busy), int'(m_busy));
    check("disp_tens", 32'(disp_tens), m_tens);
    check("disp_ones", 32'(disp_ones), m_ones);
    check("disp_stb", 32'(disp_stb), int'(m_stb));
    check("hi_tens", 32'(hi_tens), eh / 10);
    check("hi_ones", 32'(hi_ones), eh % 10);
  endtask

  task automatic model_reset();
    m_score = 0; m_pend = 0; m_val = 0; m_ready = 0;
    m_tens = 0; m_ones = 0; m_hi = 0; m_busy = 0; m_stb = 0;
  endtask

  // One clock edge of the scoring rules, expressed in decimal arithmetic.
  task automatic model_edge(input bit p, input bit c, input bit f);
    m_stb = 0;
    if (c) begin
      m_score = 0; m_pend = 0; m_val = 0;
      m_ready = cyc + SW + 1; m_busy = 1;
    end else if (!m_busy) begin
      if (m_score == MAXS) m_pend = 0;
      else if (m_pend > 0 || p) begin
        m_score++;
        if (!p) m_pend--;
        m_val = m_score; m_ready = cyc + SW + 1; m_busy = 1;
      end
    end else begin
      if (f && cyc >= m_ready) begin
        m_tens = m_val / 10; m_ones = m_val % 10; m_stb = 1; m_busy = 0;
        if (m_val > m_hi) m_hi = m_val;
      end
      if (p && m_score < MAXS && m_pend < PMAX) m_pend++;
    end
  endtask

  task automatic step(input bit p, input bit c, input bit f);
    point = p; clear = c; frame_start = f;
    @(posedge clk);
    model_edge(p, c, f);
    cyc++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic point_and_commit();
    step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; point = 1'b0; clear = 1'b0; frame_start = 1'b0;
    cyc = 0;
    model_reset();

    // reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single point, commit on a frame 20 cycles later
    step(1, 0, 0);
    check("t2_score", 32'(score), 1);
    repeat (19) step(0, 0, 0);
    step(0, 0, 1);
    check("t2_stb", 32'(disp_stb), 1);
    check("t2_ones", 32'(disp_ones), 1);

    // frame too early is not consumed
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("t3_early_stb", 32'(disp_stb), 0);
    check("t3_early_ones", 32'(disp_ones), 1);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
    check("t3_ones", 32'(disp_ones), 2);

    // burst of five points drains one per frame
    repeat (5) step(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      repeat (49) step(0, 0, 0);
      step(0, 0, 1);
      check("t4_step", 32'(disp_ones), 2 + k);
    end
    step(0, 0, 0);
    check("t4_score", 32'(score), 7);
    check("t4_busy", 32'(busy), 0);

    // reach 37, then clear with a simultaneous point
    repeat (30) point_and_commit();
    check("t6_tens", 32'(disp_tens), 3);
    check("t6_ones", 32'(disp_ones), 7);
    step(1, 1, 0);
    check("t6_clr_score", 32'(score), 0);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
    check("t6_clr_disp", 32'({disp_tens, disp_ones}), 0);
`ifdef HISCORE_EN
    check("t6_hi", 32'({hi_tens, hi_ones}), 8'h37);
`endif
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
    check("t6_mid_disp", 32'({disp_tens, disp_ones}), 0);
    check("t6_mid_score", 32'(score), 0);

    // pending counter saturates at 15
    repeat (20) step(1, 0, 0);
    repeat (20) begin
      repeat (11) step(0, 0, 0);
      step(0, 0, 1);
    end
    step(0, 0, 0);
    check("pend_sat_score", 32'(score), 16);

    // saturation at 99
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
    repeat (98) point_and_commit();
    check("t5_pre", 32'(score), 98);
    repeat (3) step(1, 0, 0);
    repeat (3) begin
      repeat (11) step(0, 0, 0);
      step(0, 0, 1);
    end
    step(1, 0, 0);
    check("t5_score", 32'(score), 99);
    check("t5_sat", 32'(saturated), 1);
    check("t5_disp", 32'({disp_tens, disp_ones}), 8'h99);
    check("t5_idle", 32'(busy), 0);

    // random traffic
    repeat (3000) step($urandom_range(0, 2) == 0, $urandom_range(0, 150) == 0,
                      $urandom_range(0, 11) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
